// File: rtl/caliptra_fpga_sync_apb_master.sv
// Single-transfer APB master: host req/rsp handshake on aclk, APB phases gated by slv_clk_en.
// Optional ACCESS-phase abort counter enabled by CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN.
module caliptra_fpga_sync_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int USER_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              slv_clk_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_pprot,
  input  logic [USER_W-1:0] req_pauser,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic [2:0]        PPROT,
  output logic [USER_W-1:0] PAUSER,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on the aclk edge where valid and ready are both 1;
  // valid may not depend on ready, and a raised rsp_valid holds its fields until taken.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                psel_q;
  logic                penable_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [2:0]          pprot_q;
  logic [USER_W-1:0]   pauser_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_slverr_q;

`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]       cnt_q;
  logic                rsp_timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pauser_q      <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_SETUP;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            paddr_q     <= req_addr;
            pprot_q     <= req_pprot;
            pauser_q    <= req_pauser;
            pwdata_q    <= req_wdata;
            pwrite_q    <= req_write;
          end
        end
        ST_SETUP: begin
          // The slave samples SETUP only at an edge where its gated clock ticks.
          if (slv_clk_en) begin
            state_q   <= ST_ACCESS;
            penable_q <= 1'b1;
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        ST_ACCESS: begin
          if (slv_clk_en && PREADY) begin
            state_q      <= ST_RESP;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pprot_q      <= '0;
            pauser_q     <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_rdata_q  <= pwrite_q ? '0 : PRDATA;
            rsp_slverr_q <= PSLVERR;
          end
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
          else if (slv_clk_en) begin
            // This stalled tick is the TIMEOUT_CYCLES-th one: abort instead of counting on.
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
              state_q       <= ST_RESP;
              psel_q        <= 1'b0;
              penable_q     <= 1'b0;
              paddr_q       <= '0;
              pprot_q       <= '0;
              pauser_q      <= '0;
              pwdata_q      <= '0;
              pwrite_q      <= 1'b0;
              rsp_valid_q   <= 1'b1;
              rsp_rdata_q   <= '0;
              rsp_slverr_q  <= 1'b1;
              rsp_timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif
  assign PADDR     = paddr_q;
  assign PPROT     = pprot_q;
  assign PAUSER    = pauser_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_caliptra_fpga_sync_apb_master.sv
// Bench for caliptra_fpga_sync_apb_master: transfer-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_caliptra_fpga_sync_apb_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int UW  = 32;
  localparam int TOC = 8;

  logic          aclk = 1'b0;
  logic          rst;
  logic          slv_clk_en;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [2:0]    req_pprot;
  logic [UW-1:0] req_pauser;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [2:0]    PPROT;
  logic [UW-1:0] PAUSER;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [1:0]    dbg_state;

  caliptra_fpga_sync_apb_master #(
    .ADDR_W(AW), .DATA_W(DW), .USER_W(UW), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .aclk(aclk), .rst(rst), .slv_clk_en(slv_clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pprot(req_pprot),
    .req_pauser(req_pauser), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PPROT(PPROT), .PAUSER(PAUSER), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave-side environment ----------------
  int          en_mode    = 0;   // 0 always on, 1 random ~70%, 2 one-in-four
  int          rdy_mode   = 0;   // 0 high, 1 random, 2 stuck low, 4 low for 3 enabled ACCESS ticks
  int          err_mode   = 0;   // 0 low, 1 high, 2 random
  logic        fix_prdata = 1'b0;
  logic [31:0] prdata_fix = 32'h0;
  int          stall_cnt  = 0;

  initial begin
    slv_clk_en = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge aclk);
      if (rdy_mode != 4) stall_cnt = 0;
      else if (PENABLE && slv_clk_en && !PREADY) stall_cnt++;
      @(posedge aclk);
      #1;
      case (en_mode)
        0:       slv_clk_en = 1'b1;
        1:       slv_clk_en = ($urandom_range(0, 9) < 7);
        default: slv_clk_en = ((cyc % 4) == 0);
      endcase
      case (rdy_mode)
        0:       PREADY = 1'b1;
        1:       PREADY = ($urandom_range(0, 1) == 1);
        2:       PREADY = 1'b0;
        default: PREADY = (stall_cnt >= 3);
      endcase
      PRDATA  = fix_prdata ? prdata_fix : $urandom;
      PSLVERR = (err_mode == 2) ? ($urandom_range(0, 1) == 1) : (err_mode == 1);
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // ph: 0 waiting for request, 1 address phase, 2 enable phase, 3 response pending
  logic [33:0]   exp_q[$];  // {timeout, slverr, rdata}
  int            ph = 0;
  int            tcnt = 0;
  logic          c_write;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [2:0]    c_pprot;
  logic [UW-1:0] c_pauser;
  logic          prev_psel = 1'b0, prev_pen = 1'b0;
  int            setup_cyc = 0, access_cyc = 0, setup_len = 0, pen_cnt = 0;

  initial begin
    forever begin
      @(negedge aclk);
      if (rst) begin
        ph = 0; tcnt = 0; exp_q.delete();
        prev_psel = 1'b0; prev_pen = 1'b0;
      end else begin
        logic bus;
        bus = (ph == 1) || (ph == 2);
        chk("req_ready", 64'(req_ready), 64'(ph == 0));
        chk("psel",      64'(PSEL),      64'(bus));
        chk("penable",   64'(PENABLE),   64'(ph == 2));
        chk("rsp_valid", 64'(rsp_valid), 64'(ph == 3));
        chk("paddr",     64'(PADDR),     bus ? 64'(c_addr)   : 64'd0);
        chk("pwdata",    64'(PWDATA),    bus ? 64'(c_wdata)  : 64'd0);
        chk("pwrite",    64'(PWRITE),    bus ? 64'(c_write)  : 64'd0);
        chk("pprot",     64'(PPROT),     bus ? 64'(c_pprot)  : 64'd0);
        chk("pauser",    64'(PAUSER),    bus ? 64'(c_pauser) : 64'd0);
`ifndef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
        chk("rsp_timeout_tied", 64'(rsp_timeout), 64'd0);
`endif
        if (ph == 3) begin
          if (exp_q.size() == 0) chk("rsp_expected", 64'd0, 64'd1);
          else chk("rsp_fields", 64'({rsp_timeout, rsp_slverr, rsp_rdata}), 64'(exp_q[0]));
        end
        if (PSEL && !prev_psel) begin setup_cyc = cyc; setup_len = 0; pen_cnt = 0; end
        if (PSEL && !PENABLE) setup_len++;
        if (PENABLE && !prev_pen) access_cyc = cyc;
        if (PENABLE) pen_cnt++;
        prev_psel = PSEL; prev_pen = PENABLE;
        case (ph)
          0: if (req_valid) begin
            c_write = req_write; c_addr = req_addr; c_wdata = req_wdata;
            c_pprot = req_pprot; c_pauser = req_pauser; ph = 1;
          end
          1: if (slv_clk_en) begin ph = 2; tcnt = 0; end
          2: if (slv_clk_en && PREADY) begin
            exp_q.push_back({1'b0, PSLVERR, c_write ? 32'h0 : PRDATA});
            ph = 3;
          end else if (slv_clk_en) begin
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
            tcnt++;
            if (tcnt == TOC) begin exp_q.push_back({1'b1, 1'b1, 32'h0}); ph = 3; end
`endif
          end
          default: if (rsp_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            ph = 0;
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, output int acc);
    logic got;
    got = 1'b0; acc = -1;
    @(posedge aclk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    req_pprot = 3'($urandom_range(0, 7)); req_pauser = $urandom;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (req_ready) begin got = 1'b1; acc = cyc; break; end
    end
    if (!got) chk("accept_bound", 64'd0, 64'd1);
    @(posedge aclk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = ~w;
  endtask

  task automatic wait_rsp(input int rr_mode, output int rc, output logic [33:0] f);
    logic got;
    got = 1'b0; rc = -1; f = '0;
    for (int i = 0; i < 3000; i++) begin
      rsp_ready = (rr_mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      @(negedge aclk);
      if (rsp_valid && rsp_ready) begin
        got = 1'b1; rc = cyc; f = {rsp_timeout, rsp_slverr, rsp_rdata}; break;
      end
      @(posedge aclk); #1;
    end
    if (!got) chk("rsp_bound", 64'd0, 64'd1);
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          acc, rc;
    logic [33:0] f;
    logic        seen;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_pprot = '0; req_pauser = '0; rsp_ready = 1'b0;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_psel",      64'(PSEL),      64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_paddr",     64'(PADDR),     64'd0);
    repeat (3) @(posedge aclk);
    #1 rst = 1'b0;

    // 1: minimum-latency read
    en_mode = 0; rdy_mode = 0; err_mode = 0; fix_prdata = 1'b1; prdata_fix = 32'hCAFEF00D;
    send(1'b0, 32'h30030000, 32'h0, acc);
    wait_rsp(1, rc, f);
    chk("t1_setup_cyc",  64'(setup_cyc),  64'(acc + 1));
    chk("t1_access_cyc", 64'(access_cyc), 64'(acc + 2));
    chk("t1_rsp_cyc",    64'(rc),         64'(acc + 3));
    chk("t1_rsp",        64'(f),          {30'd0, 34'h0CAFEF00D});

    // 2: write with three stalled slave ticks
    rdy_mode = 4;
    send(1'b1, 32'h30020008, 32'h12345678, acc);
    wait_rsp(1, rc, f);
    chk("t2_access_len", 64'(pen_cnt), 64'd4);
    chk("t2_rsp",        64'(f),       64'd0);

    // 3: slave clock ticking one cycle in four, PREADY always high
    en_mode = 2; rdy_mode = 0;
    send(1'b0, 32'h30030010, 32'h0, acc);
    wait_rsp(1, rc, f);
    chk("t3_setup_len_ok",  64'(setup_len >= 1 && setup_len <= 4), 64'd1);
    chk("t3_access_len_ok", 64'(pen_cnt >= 1 && pen_cnt <= 4),     64'd1);
    chk("t3_rsp",           64'(f), {30'd0, 34'h0CAFEF00D});

    // 4: slave error, response back-pressured
    en_mode = 0; err_mode = 1;
    send(1'b0, 32'h30030020, 32'h0, acc);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge aclk); seen = rsp_valid; end
    chk("t4_rsp_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_hold_valid",  64'(rsp_valid),  64'd1);
      chk("t4_hold_ready",  64'(req_ready),  64'd0);
      chk("t4_hold_slverr", 64'(rsp_slverr), 64'd1);
    end
    @(posedge aclk); #1;
    wait_rsp(1, rc, f);
    chk("t4_rsp", 64'(f), {30'd0, 34'h1CAFEF00D});
    err_mode = 0;

    // 5: PREADY stuck low
    rdy_mode = 2;
    send(1'b0, 32'h30030030, 32'h0, acc);
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
    wait_rsp(1, rc, f);
    chk("t5_access_len", 64'(pen_cnt), 64'(TOC));
    chk("t5_rsp",        64'(f),       {30'd0, 34'h300000000});
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin @(negedge aclk); if (rsp_valid) seen = 1'b1; end
    chk("t5_no_rsp", 64'(seen), 64'd0);
    @(posedge aclk); #1;
    rdy_mode = 0;
    wait_rsp(1, rc, f);
    chk("t5_late_rsp", 64'(f), {30'd0, 34'h0CAFEF00D});
`endif

    // 6: reset during ACCESS
    rdy_mode = 2;
    send(1'b0, 32'h30030040, 32'h0, acc);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge aclk); seen = PENABLE; end
    chk("t6_in_access", 64'(seen), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_psel",      64'(PSEL),      64'd0);
    chk("t6_penable",   64'(PENABLE),   64'd0);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge aclk);
    #1 rst = 1'b0; rdy_mode = 0;
    @(negedge aclk);
    chk("t6_req_ready", 64'(req_ready), 64'd1);
    send(1'b0, 32'h30030050, 32'h0, acc);
    wait_rsp(1, rc, f);
    chk("t6_rsp", 64'(f), {30'd0, 34'h0CAFEF00D});

    // randomized traffic
    fix_prdata = 1'b0; err_mode = 2; rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      en_mode = $urandom_range(0, 2);
      send($urandom_range(0, 1) == 1, $urandom, $urandom, acc);
      wait_rsp($urandom_range(0, 1), rc, f);
    end

    repeat (3) @(negedge aclk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
